// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result bus for pipelined_ripple_adder.
// The ovf signal exists only when ADDER_OVF_FLAG_EN is defined.
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             co;
`ifdef ADDER_OVF_FLAG_EN
  logic             ovf;

  modport master (
    output in_valid, A, B, ci, sub, out_ready,
    input  in_ready, out_valid, SUM, co, ovf
  );

  modport slave (
    input  in_valid, A, B, ci, sub, out_ready,
    output in_ready, out_valid, SUM, co, ovf
  );
`else
  modport master (
    output in_valid, A, B, ci, sub, out_ready,
    input  in_ready, out_valid, SUM, co
  );

  modport slave (
    input  in_valid, A, B, ci, sub, out_ready,
    output in_ready, out_valid, SUM, co
  );
`endif
endinterface

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple add/subtract: WIDTH bits split into CHUNK-bit ripple
// slices, one slice per stage, carry registered between stages.
// Global stall: every stage holds while a result waits on the consumer.
// Optional signed-overflow output enabled by defining ADDER_OVF_FLAG_EN.
module pipelined_ripple_adder #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input logic                    CK,
  input logic                    rst,
  pipelined_ripple_adder_if.slave bus
);
  localparam int NSTAGES = WIDTH / CHUNK;
  localparam int LAST    = NSTAGES - 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("pipelined_ripple_adder: WIDTH must be a multiple of CHUNK");
  end

  // Plain bit-serial ripple over one slice; returns {carry_out, sum}.
  function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             c0);
    logic             c;
    logic [CHUNK-1:0] s;
    c = c0;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic             advance;

  // Stage registers. sum_q[k] holds slices 0..k; a_q/b_q carry operands forward.
  logic [WIDTH-1:0] a_q     [NSTAGES];
  logic [WIDTH-1:0] b_q     [NSTAGES];
  logic [WIDTH-1:0] sum_q   [NSTAGES];
  logic             c_q     [NSTAGES];
  logic             v_q     [NSTAGES];

  logic [WIDTH-1:0] a_in    [NSTAGES];
  logic [WIDTH-1:0] b_in    [NSTAGES];
  logic [WIDTH-1:0] part_in [NSTAGES];
  logic             c_in    [NSTAGES];
  logic             v_in    [NSTAGES];

  logic [CHUNK:0]   slice_res [NSTAGES];
  logic [WIDTH-1:0] sum_d     [NSTAGES];

  assign advance      = !v_q[LAST] || bus.out_ready;
  assign bus.in_ready = advance;

  // Route stage inputs: stage 0 from the bus (subtract folded in), others from the stage behind.
  always_comb begin
    a_in[0]    = bus.A;
    b_in[0]    = bus.sub ? ~bus.B : bus.B;
    c_in[0]    = bus.ci ^ bus.sub;
    part_in[0] = '0;
    v_in[0]    = bus.in_valid;
    for (int k = 1; k < NSTAGES; k++) begin
      a_in[k]    = a_q[k-1];
      b_in[k]    = b_q[k-1];
      c_in[k]    = c_q[k-1];
      part_in[k] = sum_q[k-1];
      v_in[k]    = v_q[k-1];
    end
  end

  // Each stage ripples its own slice and splices it into the running sum.
  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      slice_res[k] = slice_add(a_in[k][k*CHUNK +: CHUNK], b_in[k][k*CHUNK +: CHUNK], c_in[k]);
      sum_d[k]     = part_in[k];
      sum_d[k][k*CHUNK +: CHUNK] = slice_res[k][CHUNK-1:0];
    end
  end

  // Advance all stages together; reset clears valids and zeroes the data path.
  always_ff @(posedge CK) begin
    if (rst) begin
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= slice_res[k][CHUNK];
        v_q[k]   <= v_in[k];
      end
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.SUM       = sum_q[LAST];
  assign bus.co        = c_q[LAST];

`ifdef ADDER_OVF_FLAG_EN
  logic ovf_q;

  // Carry into the MSB is recovered as a^b^sum at that bit; XOR with carry out gives signed overflow.
  always_ff @(posedge CK) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ sum_d[LAST][WIDTH-1]
               ^ slice_res[LAST][CHUNK];
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder (WIDTH=12, CHUNK=4, latency 3).
module tb_pipelined_ripple_adder;
  logic CK = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 CK = ~CK;

  pipelined_ripple_adder_if #(.WIDTH(12)) bus ();

  pipelined_ripple_adder #(.WIDTH(12), .CHUNK(4)) dut (
    .CK  (CK),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] a, input logic [11:0] b,
                       input logic c, input logic s);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.ci       = c;
    bus.sub      = s;
  endtask

  // exp = {ovf, co, SUM[11:0]}
  task automatic do_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                       input logic c, input logic s, input logic [13:0] exp);
    drive(1'b1, a, b, c, s);
    step();
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    step();
    chk({tag, "_early"}, {15'd0, bus.out_valid}, 16'd0);
    step();
    chk({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
    chk({tag, "_sum"},   {4'd0, bus.SUM},        {4'd0, exp[11:0]});
    chk({tag, "_co"},    {15'd0, bus.co},        {15'd0, exp[12]});
`ifdef ADDER_OVF_FLAG_EN
    chk({tag, "_ovf"},   {15'd0, bus.ovf},       {15'd0, exp[13]});
`endif
  endtask

  logic [11:0] bp_exp [4];

  initial begin
    // Reset with in_valid high: reset must win.
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 12'h0AA, 12'h055, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    #1;
    chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_sum",   {4'd0, bus.SUM},        16'd0);
    chk("rst_co",    {15'd0, bus.co},        16'd0);
    chk("rst_ready", {15'd0, bus.in_ready},  16'd1);
`ifdef ADDER_OVF_FLAG_EN
    chk("rst_ovf",   {15'd0, bus.ovf},       16'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_noacc", {15'd0, bus.out_valid}, 16'd0);
    end

    // Directed single operations: {ovf, co, SUM}
    do_op("add_0ff_1",  12'h0FF, 12'h001, 1'b0, 1'b0, {1'b0, 1'b0, 12'h100});
    do_op("add_fff_1",  12'hFFF, 12'h001, 1'b0, 1'b0, {1'b0, 1'b1, 12'h000});
    do_op("sub_5_7",    12'h005, 12'h007, 1'b0, 1'b1, {1'b0, 1'b0, 12'hFFE});
    do_op("sub_800_1",  12'h800, 12'h001, 1'b0, 1'b1, {1'b1, 1'b1, 12'h7FF});
    do_op("add_ci",     12'h123, 12'h456, 1'b1, 1'b0, {1'b0, 1'b0, 12'h57A});
    do_op("add_7ff_1",  12'h7FF, 12'h001, 1'b0, 1'b0, {1'b1, 1'b0, 12'h800});
    do_op("sub_ci",     12'h010, 12'h003, 1'b1, 1'b1, {1'b0, 1'b1, 12'h00C});

    // Back-to-back: results on consecutive cycles, no gaps.
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive(1'b1, 12'(c), 12'(c), 1'b0, 1'b0);
      else       drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
      step();
      if (c >= 2) begin
        chk("b2b_valid", {15'd0, bus.out_valid}, {15'd0, (c - 2) < 8});
        if (c - 2 < 8) chk("b2b_sum", {4'd0, bus.SUM}, 16'(2 * (c - 2)));
      end else begin
        chk("b2b_lat", {15'd0, bus.out_valid}, 16'd0);
      end
    end

    // Backpressure: 4 ops, stall 5 cycles once the first result appears.
    bp_exp[0] = 12'h001;
    bp_exp[1] = 12'h112;
    bp_exp[2] = 12'h223;
    bp_exp[3] = 12'h334;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 12'(j * 'h111), 12'h001, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 12'h333, 12'h001, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      chk("bp_ready",  {15'd0, bus.in_ready},  16'd0);
      chk("bp_valid",  {15'd0, bus.out_valid}, 16'd1);
      chk("bp_hold",   {4'd0, bus.SUM},        {4'd0, bp_exp[0]});
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release", {15'd0, bus.in_ready}, 16'd1);
    for (int r = 0; r < 4; r++) begin
      chk("bp_out_valid", {15'd0, bus.out_valid}, 16'd1);
      chk("bp_out_sum",   {4'd0, bus.SUM},        {4'd0, bp_exp[r]});
      step();
      if (r == 0) drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    end
    chk("bp_drained", {15'd0, bus.out_valid}, 16'd0);

    // Mid-operation reset discards in-flight ops.
    drive(1'b1, 12'h111, 12'h222, 1'b0, 1'b0);
    step();
    drive(1'b1, 12'h100, 12'h100, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b1, 12'h0F0, 12'h00F, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    chk("mrst_now", {15'd0, bus.out_valid}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_quiet", {15'd0, bus.out_valid}, 16'd0);
    end
    do_op("post_rst", 12'h321, 12'h123, 1'b0, 1'b0, {1'b0, 1'b0, 12'h444});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
